// File: rtl/dragon_segment_reader_pkg.sv
// -----------------------------------------------------------------------------
// dragon_segment_reader_pkg
// Shared definitions for the dragon segment reader:
//   - default body size (segment count) and segment word width
//   - field layout of one segment word: [9:8] orientation, [7:4] X, [3:0] Y
//   - orientation encodings and the reader FSM state encoding
// -----------------------------------------------------------------------------
package dragon_segment_reader_pkg;

  localparam int NUM_SEG_DEF = 7;
  localparam int SEG_W_DEF   = 10;

  localparam int ORIENT_LSB = 8;
  localparam int ORIENT_W   = 2;
  localparam int X_LSB      = 4;
  localparam int X_W        = 4;
  localparam int Y_LSB      = 0;
  localparam int Y_W        = 4;

  typedef enum logic [1:0] {
    ORIENT_UP    = 2'b00,
    ORIENT_RIGHT = 2'b01,
    ORIENT_DOWN  = 2'b10,
    ORIENT_LEFT  = 2'b11
  } orient_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/dragon_seg_compare.sv
// -----------------------------------------------------------------------------
// dragon_seg_compare
// Combinational decode of one segment word against a tile query.
// Ports:
//   seg_word  in  SEG_W  packed segment word (orientation, X, Y)
//   enable    in  1      display enable bit for this segment
//   query_x   in  4      queried tile column
//   query_y   in  4      queried tile row
//   match     out 1      segment is visible and sits on the queried tile
//   orient    out 2      orientation field of the segment word
// -----------------------------------------------------------------------------
module dragon_seg_compare
  import dragon_segment_reader_pkg::*;
#(
  parameter int SEG_W = SEG_W_DEF
) (
  input  logic [SEG_W-1:0]    seg_word,
  input  logic                enable,
  input  logic [X_W-1:0]      query_x,
  input  logic [Y_W-1:0]      query_y,
  output logic                match,
  output logic [ORIENT_W-1:0] orient
);

  logic [X_W-1:0] seg_x;
  logic [Y_W-1:0] seg_y;

  assign seg_x  = seg_word[X_LSB +: X_W];
  assign seg_y  = seg_word[Y_LSB +: Y_W];
  assign orient = seg_word[ORIENT_LSB +: ORIENT_W];
  assign match  = enable && (seg_x == query_x) && (seg_y == query_y);

endmodule

// File: rtl/dragon_segment_reader.sv
// -----------------------------------------------------------------------------
// dragon_segment_reader
// Answers "which visible body segment occupies tile (x,y)?" queries. A query
// snapshots the segment bus and enables, then scans one segment per cycle and
// returns hit / lowest matching index / its orientation / match count.
// Ports:
//   clk          in   1              clock, rising edge
//   reset        in   1              asynchronous reset, active low
//   seg_bus      in   NUM_SEG*SEG_W  packed segment words, segment 0 = head
//   display_en   in   NUM_SEG        per-segment visibility
//   query_valid  in   1              query request
//   query_ready  out  1              query accepted this cycle (IDLE only)
//   query_x/y    in   4              queried tile
//   resp_valid   out  1              response fields valid
//   resp_ready   in   1              consumer takes the response
//   resp_hit     out  1              at least one visible match
//   resp_index   out  3              lowest matching segment index
//   resp_orient  out  2              orientation of that segment
//   resp_count   out  3              number of matches, saturating at 7
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | query_ready high, waiting for a query
// SCAN  | walking the snapshot, one segment per cycle, then publishing
// RESP  | resp_valid high, outputs frozen until resp_ready
// -----------------------------------------------------------------------------
module dragon_segment_reader
  import dragon_segment_reader_pkg::*;
#(
  parameter int NUM_SEG = NUM_SEG_DEF,
  parameter int SEG_W   = SEG_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SEG*SEG_W-1:0] seg_bus,
  input  logic [NUM_SEG-1:0]       display_en,
  input  logic                     query_valid,
  output logic                     query_ready,
  input  logic [3:0]               query_x,
  input  logic [3:0]               query_y,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_hit,
  output logic [2:0]               resp_index,
  output logic [1:0]               resp_orient,
  output logic [2:0]               resp_count
);

  // Index must reach NUM_SEG: that extra step is the publish cycle, which
  // gives the fixed NUM_SEG+1 edge latency from accept to resp_valid.
  localparam int IDX_W = $clog2(NUM_SEG + 1);
  localparam logic [IDX_W-1:0] PUBLISH_IDX = IDX_W'(NUM_SEG);

  state_e                   state;
  logic [IDX_W-1:0]         scan_idx;
  logic [NUM_SEG*SEG_W-1:0] seg_snap;
  logic [NUM_SEG-1:0]       en_snap;
  logic [3:0]               qx_snap;
  logic [3:0]               qy_snap;

  logic                     acc_hit;
  logic [2:0]               acc_index;
  logic [1:0]               acc_orient;
  logic [2:0]               acc_count;

  logic [SEG_W-1:0]         cur_word;
  logic                     cur_en;
  logic                     cur_match;
  logic [1:0]               cur_orient;

  // Out-of-range index (publish cycle) selects a disabled null segment.
  always_comb begin
    cur_word = '0;
    cur_en   = 1'b0;
    for (int i = 0; i < NUM_SEG; i++) begin
      if (scan_idx == IDX_W'(i)) begin
        cur_word = seg_snap[i*SEG_W +: SEG_W];
        cur_en   = en_snap[i];
      end
    end
  end

  dragon_seg_compare #(
    .SEG_W (SEG_W)
  ) u_compare (
    .seg_word (cur_word),
    .enable   (cur_en),
    .query_x  (qx_snap),
    .query_y  (qy_snap),
    .match    (cur_match),
    .orient   (cur_orient)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      scan_idx    <= '0;
      seg_snap    <= '0;
      en_snap     <= '0;
      qx_snap     <= '0;
      qy_snap     <= '0;
      acc_hit     <= 1'b0;
      acc_index   <= '0;
      acc_orient  <= ORIENT_UP;
      acc_count   <= '0;
      query_ready <= 1'b1;
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_index  <= '0;
      resp_orient <= ORIENT_UP;
      resp_count  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (query_valid && query_ready) begin
            seg_snap    <= seg_bus;
            en_snap     <= display_en;
            qx_snap     <= query_x;
            qy_snap     <= query_y;
            scan_idx    <= '0;
            acc_hit     <= 1'b0;
            acc_index   <= '0;
            acc_orient  <= ORIENT_UP;
            acc_count   <= '0;
            query_ready <= 1'b0;
            state       <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (scan_idx == PUBLISH_IDX) begin
            resp_hit    <= acc_hit;
            resp_index  <= acc_index;
            resp_orient <= acc_orient;
            resp_count  <= acc_count;
            resp_valid  <= 1'b1;
            state       <= ST_RESP;
          end else begin
            if (cur_match) begin
              // Only the first match names the segment; later ones just count.
              if (!acc_hit) begin
                acc_hit    <= 1'b1;
                acc_index  <= 3'(scan_idx);
                acc_orient <= cur_orient;
              end
              if (acc_count != 3'd7) begin
                acc_count <= acc_count + 3'd1;
              end
            end
            scan_idx <= scan_idx + IDX_W'(1);
          end
        end
        ST_RESP: begin
          // query_ready rises only after this edge, so no accept can
          // coincide with the response handshake.
          if (resp_ready) begin
            resp_valid  <= 1'b0;
            query_ready <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dragon_segment_reader.sv
module tb_dragon_segment_reader;

  localparam int NS  = 7;
  localparam int SW  = 10;
  localparam int LAT = NS + 1;

  logic           clk;
  logic           reset;
  logic [NS*SW-1:0] seg_bus;
  logic [NS-1:0]  display_en;
  logic           query_valid;
  logic           query_ready;
  logic [3:0]     query_x;
  logic [3:0]     query_y;
  logic           resp_valid;
  logic           resp_ready;
  logic           resp_hit;
  logic [2:0]     resp_index;
  logic [1:0]     resp_orient;
  logic [2:0]     resp_count;

  int n_cmp = 0;
  int n_bad = 0;

  dragon_segment_reader #(.NUM_SEG(NS), .SEG_W(SW)) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_bus     (seg_bus),
    .display_en  (display_en),
    .query_valid (query_valid),
    .query_ready (query_ready),
    .query_x     (query_x),
    .query_y     (query_y),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_hit    (resp_hit),
    .resp_index  (resp_index),
    .resp_orient (resp_orient),
    .resp_count  (resp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string          name;
    logic [NS-1:0][SW-1:0] segs;
    logic [NS-1:0]  en;
    logic [3:0]     qx;
    logic [3:0]     qy;
    int             hold;
    int             pert_cyc;
    logic [NS-1:0][SW-1:0] pert;
    logic           eh;
    logic [2:0]     ei;
    logic [1:0]     eo;
    logic [2:0]     ec;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: collect all visible matches, then derive the response fields.
  task automatic model(input logic [NS*SW-1:0] bus, input logic [NS-1:0] en,
                       input logic [3:0] qx, input logic [3:0] qy,
                       output logic eh, output logic [2:0] ei,
                       output logic [1:0] eo, output logic [2:0] ec);
    int hits[$];
    logic [SW-1:0] w;
    for (int i = 0; i < NS; i++) begin
      w = bus[i*SW +: SW];
      if (en[i] && w[7:4] == qx && w[3:0] == qy) hits.push_back(i);
    end
    eh = hits.size() > 0;
    ei = eh ? 3'(hits[0]) : 3'd0;
    w  = eh ? bus[hits[0]*SW +: SW] : '0;
    eo = w[9:8];
    ec = (hits.size() > 7) ? 3'd7 : 3'(hits.size());
  endtask

  task automatic run_query(input string tag, input logic [NS*SW-1:0] bus,
                           input logic [NS-1:0] en, input logic [3:0] qx,
                           input logic [3:0] qy, input int hold,
                           input int pert_cyc, input logic [NS*SW-1:0] pert,
                           input logic eh, input logic [2:0] ei,
                           input logic [1:0] eo, input logic [2:0] ec);
    int cnt;
    int lat;
    bit seen;
    cnt = 0;
    while (!query_ready && cnt < 20) begin
      @(posedge clk); #1; cnt++;
    end
    chk({tag, " query_ready_idle"}, int'(query_ready), 1);
    seg_bus = bus; display_en = en; query_x = qx; query_y = qy;
    query_valid = 1'b1;
    @(posedge clk); #1;
    query_valid = 1'b0;
    query_x = 4'($urandom); query_y = 4'($urandom);
    display_en = NS'($urandom);
    chk({tag, " query_ready_scan"}, int'(query_ready), 0);
    lat = 0; seen = 0;
    while (!seen && lat < 20) begin
      if (lat == pert_cyc) seg_bus = pert;
      @(posedge clk); #1;
      lat++;
      seen = resp_valid;
    end
    chk({tag, " latency"}, lat, LAT);
    for (int h = 0; h <= hold; h++) begin
      chk({tag, " hit"},    int'(resp_hit),    int'(eh));
      chk({tag, " index"},  int'(resp_index),  int'(ei));
      chk({tag, " orient"}, int'(resp_orient), int'(eo));
      chk({tag, " count"},  int'(resp_count),  int'(ec));
      chk({tag, " resp_valid_hold"}, int'(resp_valid), 1);
      chk({tag, " query_ready_resp"}, int'(query_ready), 0);
      if (h == hold) begin
        resp_ready = 1'b1;
        query_valid = 1'b1;
      end
      @(posedge clk); #1;
    end
    resp_ready = 1'b0;
    query_valid = 1'b0;
    chk({tag, " resp_valid_after"}, int'(resp_valid), 0);
    chk({tag, " query_ready_after"}, int'(query_ready), 1);
    chk({tag, " hit_retained"}, int'(resp_hit), int'(eh));
    chk({tag, " count_retained"}, int'(resp_count), int'(ec));
  endtask

  initial begin
    logic [NS-1:0][SW-1:0] segs;
    logic [NS-1:0][SW-1:0] pert;
    logic [NS-1:0] en;
    logic [3:0] qx, qy;
    logic eh; logic [2:0] ei; logic [1:0] eo; logic [2:0] ec;
    int cnt;
    int seen_cnt;

    for (int i = 0; i < 8; i++) begin
      tbl[i].segs = '0; tbl[i].pert = '0; tbl[i].hold = 0; tbl[i].pert_cyc = -1;
    end
    tbl[0].name = "head_match"; tbl[0].segs[0] = 10'h235; tbl[0].en = 7'h7F;
    tbl[0].qx = 4'h3; tbl[0].qy = 4'h5;
    {tbl[0].eh, tbl[0].ei, tbl[0].eo, tbl[0].ec} = {1'b1, 3'd0, 2'd2, 3'd1};
    tbl[1].name = "two_match_hold5"; tbl[1].segs[2] = 10'h171; tbl[1].segs[5] = 10'h171;
    tbl[1].en = 7'h7F; tbl[1].qx = 4'h7; tbl[1].qy = 4'h1; tbl[1].hold = 5;
    {tbl[1].eh, tbl[1].ei, tbl[1].eo, tbl[1].ec} = {1'b1, 3'd2, 2'd1, 3'd2};
    tbl[2].name = "masked"; tbl[2].segs[1] = 10'h3A9; tbl[2].en = 7'h01;
    tbl[2].qx = 4'hA; tbl[2].qy = 4'h9;
    {tbl[2].eh, tbl[2].ei, tbl[2].eo, tbl[2].ec} = {1'b0, 3'd0, 2'd0, 3'd0};
    tbl[3].name = "all_seven"; tbl[3].segs = {7{10'h0C4}}; tbl[3].en = 7'h7F;
    tbl[3].qx = 4'hC; tbl[3].qy = 4'h4; tbl[3].hold = 2;
    {tbl[3].eh, tbl[3].ei, tbl[3].eo, tbl[3].ec} = {1'b1, 3'd0, 2'd0, 3'd7};
    tbl[4].name = "none_enabled"; tbl[4].segs = {7{10'h0C4}}; tbl[4].en = 7'h00;
    tbl[4].qx = 4'hC; tbl[4].qy = 4'h4;
    {tbl[4].eh, tbl[4].ei, tbl[4].eo, tbl[4].ec} = {1'b0, 3'd0, 2'd0, 3'd0};
    tbl[5].name = "tail_only"; tbl[5].segs[6] = 10'h1FF; tbl[5].en = 7'h40;
    tbl[5].qx = 4'hF; tbl[5].qy = 4'hF; tbl[5].hold = 1;
    {tbl[5].eh, tbl[5].ei, tbl[5].eo, tbl[5].ec} = {1'b1, 3'd6, 2'd1, 3'd1};
    tbl[6].name = "midscan_change"; tbl[6].segs = {7{10'h355}}; tbl[6].en = 7'h7F;
    tbl[6].qx = 4'h2; tbl[6].qy = 4'h2; tbl[6].pert_cyc = 2;
    tbl[6].pert = {7{10'h322}};
    {tbl[6].eh, tbl[6].ei, tbl[6].eo, tbl[6].ec} = {1'b0, 3'd0, 2'd0, 3'd0};
    tbl[7].name = "zero_tile"; tbl[7].segs[4] = 10'h3F0; tbl[7].en = 7'h28;
    tbl[7].qx = 4'h0; tbl[7].qy = 4'h0;
    {tbl[7].eh, tbl[7].ei, tbl[7].eo, tbl[7].ec} = {1'b1, 3'd3, 2'd0, 3'd2};

    reset = 1'b0; seg_bus = '0; display_en = '0; query_valid = 1'b0;
    query_x = '0; query_y = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst resp_valid", int'(resp_valid), 0);
    chk("rst resp_hit", int'(resp_hit), 0);
    chk("rst resp_count", int'(resp_count), 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("rst query_ready", int'(query_ready), 1);

    for (int v = 0; v < 8; v++)
      run_query(tbl[v].name, tbl[v].segs, tbl[v].en, tbl[v].qx, tbl[v].qy,
                tbl[v].hold, tbl[v].pert_cyc, tbl[v].pert,
                tbl[v].eh, tbl[v].ei, tbl[v].eo, tbl[v].ec);

    // Reset mid-scan after a hit response left nonzero data on the outputs.
    segs = '0; segs[4] = 10'h2AB;
    seg_bus = segs; display_en = 7'h7F; query_x = 4'hA; query_y = 4'hB;
    query_valid = 1'b1;
    @(posedge clk); #1;
    query_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    chk("midrst resp_valid", int'(resp_valid), 0);
    chk("midrst resp_hit", int'(resp_hit), 0);
    chk("midrst resp_index", int'(resp_index), 0);
    chk("midrst resp_orient", int'(resp_orient), 0);
    chk("midrst resp_count", int'(resp_count), 0);
    @(negedge clk); reset = 1'b1;
    seen_cnt = 0;
    for (cnt = 0; cnt < 12; cnt++) begin
      @(posedge clk); #1;
      if (resp_valid) seen_cnt++;
    end
    chk("midrst no_response", seen_cnt, 0);
    chk("midrst query_ready", int'(query_ready), 1);
    model(segs, 7'h7F, 4'hA, 4'hB, eh, ei, eo, ec);
    run_query("after_reset", segs, 7'h7F, 4'hA, 4'hB, 0, -1, '0, eh, ei, eo, ec);

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < NS; i++) begin
        segs[i] = {2'($urandom), 4'($urandom_range(0, 2)), 4'($urandom_range(0, 2))};
        pert[i] = SW'($urandom);
      end
      en = NS'($urandom);
      qx = 4'($urandom_range(0, 2));
      qy = 4'($urandom_range(0, 2));
      model(segs, en, qx, qy, eh, ei, eo, ec);
      run_query($sformatf("rand%0d", r), segs, en, qx, qy, $urandom_range(0, 3),
                $urandom_range(0, 7), pert, eh, ei, eo, ec);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
